qspi_fetch: RTL and testbench

- Responder end of the word-list fetch interface: accepts a one-cycle `fetch` request with a 24-bit byte address and performs a quad-output read from the external QSPI flash.
- Returns one 32-bit big-endian word on `fetch_result`.
- Sits between the game logic and the flash pins; `fetch_result` holds its value until the next read completes, so consumers may sample it at any later time.

---
 rtl/qspi_fetch_if.sv | 17 +
 rtl/qspi_fetch.sv | 213 +++++++++++++++++++++
 tb/tb_qspi_fetch.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/qspi_fetch_if.sv
// qspi_fetch_if -- word-fetch request/response bundle between the game logic
// (master) and the QSPI flash reader (slave).
//   fetch        : one-cycle read request, honoured only while busy=0
//   fetch_addr   : 24-bit byte address, captured on the accepting edge
//   fetch_result : last 32-bit big-endian word read, held until the next done
//   done         : one-cycle pulse in the cycle fetch_result updates
//   busy         : high from the cycle after acceptance through CS high time
interface qspi_fetch_if;
  logic        fetch;
  logic [23:0] fetch_addr;
  logic [31:0] fetch_result;
  logic        done;
  logic        busy;

  modport master (output fetch, fetch_addr, input fetch_result, done, busy);
  modport slave  (input fetch, fetch_addr, output fetch_result, done, busy);
endinterface

// File: rtl/qspi_fetch.sv
// qspi_fetch -- responder for one-word fetches from an external QSPI flash.
// Default build issues a quad-output read (0x6B): opcode and address go out
// serially on IO0, then dummy cycles, then 8 nibbles come back on IO3..IO0.
// Defining QSPI_QUAD_IO_EN switches to quad I/O read (0xEB): the address is
// sent nibble-wise on IO3..IO0, followed by a 2-SCK mode byte of 0x00.
// Ports:
//   clk, rst_n     : system clock, asynchronous active-low reset
//   fbus (slave)   : fetch / fetch_addr / fetch_result / done / busy
//   spi_cs_n       : flash chip select, active-low
//   spi_sck        : flash clock, CPOL=0, clk/(2*CLK_DIV)
//   spi_io_out/oe  : IO0..IO3 drive values and per-line enables
//   spi_io_in      : IO0..IO3 sampled values
//
// state | meaning
// IDLE  | waiting for fetch; CS high
// CMD   | 8 SCK cycles of opcode on IO0
// ADDR  | address phase (24 SCK serial, or 6 SCK quad)
// MODE  | quad I/O only: 2 SCK cycles driving 0x00
// DUMMY | DUMMY_CYCLES SCK cycles, bus released
// DATA  | 8 SCK cycles sampling nibbles, then one cycle to publish the word
// CSH   | CS held high CSH_CYCLES clk cycles before returning to IDLE
module qspi_fetch #(
  parameter int CLK_DIV      = 1,
  parameter int DUMMY_CYCLES = 8,
  parameter int CSH_CYCLES   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  qspi_fetch_if.slave fbus,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic [3:0]  spi_io_out,
  output logic [3:0]  spi_io_oe,
  input  logic [3:0]  spi_io_in
);

`ifdef QSPI_QUAD_IO_EN
  localparam logic [7:0] OPCODE   = 8'hEB;
  localparam logic [5:0] ADDR_LEN = 6'd6;
`else
  localparam logic [7:0] OPCODE   = 8'h6B;
  localparam logic [5:0] ADDR_LEN = 6'd24;
`endif
  localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);
  localparam logic [7:0] CSH_RELOAD = 8'(CSH_CYCLES - 1);
  localparam logic [5:0] DUMMY_LEN  = 6'(DUMMY_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
`ifdef QSPI_QUAD_IO_EN
    MODE,
`endif
    DUMMY,
    DATA,
    CSH
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  tmr;         // SCK half-period divider, reused as CS-high timer
  logic [5:0]  sck_cnt;     // SCK cycles left in the current phase, minus one
  logic [5:0]  next_len;
  logic [31:0] tx;          // opcode+address, MSB drives the pads
  logic [31:0] rx;
  logic        fin;         // all data sampled; publish on the next cycle
  logic        tick;
  logic        phase_end;
  logic        quad_phase;
  logic [31:0] result_q;
  logic        done_q;
  logic        busy_q;

  assign fbus.fetch_result = result_q;
  assign fbus.done         = done_q;
  assign fbus.busy         = busy_q;

  assign tick      = (state != IDLE) && (state != CSH) && !fin && (tmr == 8'd0);
  assign phase_end = tick && spi_sck && (sck_cnt == 6'd0);

`ifdef QSPI_QUAD_IO_EN
  assign quad_phase = (state == ADDR) || (state == MODE);
`else
  assign quad_phase = 1'b0;
`endif

  always_comb begin
    next_len = 6'd0;
    case (state)
      CMD:   next_len = ADDR_LEN - 6'd1;
`ifdef QSPI_QUAD_IO_EN
      ADDR:  next_len = 6'd1;
      MODE:  next_len = DUMMY_LEN;
`else
      ADDR:  next_len = DUMMY_LEN;
`endif
      DUMMY: next_len = 6'd7;
      default: next_len = 6'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (fbus.fetch) state_nxt = CMD;
      CMD:   if (phase_end) state_nxt = ADDR;
`ifdef QSPI_QUAD_IO_EN
      ADDR:  if (phase_end) state_nxt = MODE;
      MODE:  if (phase_end) state_nxt = DUMMY;
`else
      ADDR:  if (phase_end) state_nxt = DUMMY;
`endif
      DUMMY: if (phase_end) state_nxt = DATA;
      DATA:  if (fin) state_nxt = CSH;
      CSH:   if (tmr == 8'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    spi_io_out = 4'h0;
    spi_io_oe  = 4'h0;
    case (state)
      CMD: begin
        spi_io_out = {3'b000, tx[31]};
        spi_io_oe  = 4'b0001;
      end
`ifdef QSPI_QUAD_IO_EN
      ADDR, MODE: begin
        spi_io_out = tx[31:28];
        spi_io_oe  = 4'b1111;
      end
`else
      ADDR: begin
        spi_io_out = {3'b000, tx[31]};
        spi_io_oe  = 4'b0001;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr      <= 8'd0;
      sck_cnt  <= 6'd0;
      tx       <= 32'd0;
      rx       <= 32'd0;
      fin      <= 1'b0;
      result_q <= 32'd0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      spi_cs_n <= 1'b1;
      spi_sck  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (fbus.fetch) begin
            tx       <= {OPCODE, fbus.fetch_addr};
            spi_cs_n <= 1'b0;
            spi_sck  <= 1'b0;
            busy_q   <= 1'b1;
            tmr      <= DIV_RELOAD;
            sck_cnt  <= 6'd7;
            fin      <= 1'b0;
          end
        end
        CSH: begin
          if (tmr == 8'd0) busy_q <= 1'b0;
          else             tmr    <= tmr - 8'd1;
        end
        default: begin
          if (fin) begin
            result_q <= rx;
            done_q   <= 1'b1;
            spi_cs_n <= 1'b1;
            spi_sck  <= 1'b0;
            fin      <= 1'b0;
            tmr      <= CSH_RELOAD;
          end else if (tmr != 8'd0) begin
            tmr <= tmr - 8'd1;
          end else begin
            tmr     <= DIV_RELOAD;
            spi_sck <= ~spi_sck;
            if (!spi_sck) begin
              // rising SCK: flash data is stable, capture it
              if (state == DATA) rx <= {rx[27:0], spi_io_in};
            end else begin
              // falling SCK: present the next bit/nibble
              tx <= quad_phase ? {tx[27:0], 4'h0} : {tx[30:0], 1'b0};
              if (sck_cnt != 6'd0) begin
                sck_cnt <= sck_cnt - 6'd1;
              end else begin
                sck_cnt <= next_len;
                if (state == DATA) fin <= 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

  ap_clk_div_range: assert property (@(posedge clk) (CLK_DIV >= 1) && (CLK_DIV <= 15))
    else $error("qspi_fetch: CLK_DIV=%0d outside 1..15", CLK_DIV);

endmodule

// File: tb/tb_qspi_fetch.sv
module tb_qspi_fetch;
  localparam int DUMMY = 8;
  localparam int CSH   = 2;
  localparam int DIV0  = 1;
  localparam int DIV1  = 3;
`ifdef QSPI_QUAD_IO_EN
  localparam bit QUAD = 1'b1;
`else
  localparam bit QUAD = 1'b0;
`endif
  localparam int NSCK = QUAD ? (24 + DUMMY) : (40 + DUMMY);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  qspi_fetch_if bus0 ();
  qspi_fetch_if bus1 ();
  logic       cs_n0, sck0, cs_n1, sck1;
  logic [3:0] io_out0, io_oe0, io_in0, io_out1, io_oe1, io_in1;

  qspi_fetch #(.CLK_DIV(DIV0), .DUMMY_CYCLES(DUMMY), .CSH_CYCLES(CSH)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .fbus(bus0), .spi_cs_n(cs_n0), .spi_sck(sck0),
    .spi_io_out(io_out0), .spi_io_oe(io_oe0), .spi_io_in(io_in0));

  qspi_fetch #(.CLK_DIV(DIV1), .DUMMY_CYCLES(DUMMY), .CSH_CYCLES(CSH)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .fbus(bus1), .spi_cs_n(cs_n1), .spi_sck(sck1),
    .spi_io_out(io_out1), .spi_io_oe(io_oe1), .spi_io_in(io_in1));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- flash model: counts SCK rises per CS window ----------------
  logic [31:0] fl_word [2];
  int          rc [2];
  logic        ps [2];
  logic [7:0]  trace [2][64];   // {io_out, io_oe} seen at each SCK rise
  int          hi [2];          // consecutive clk cycles with CS high

  function automatic logic [3:0] flash_nib(input logic [31:0] w, input int r);
    int idx;
    idx = r - (NSCK - 8);
    if (idx < 0 || idx > 7) return 4'h0;
    return w[31 - 4*idx -: 4];
  endfunction

  always @(negedge clk) begin
    if (cs_n0) begin
      rc[0] = 0;
      io_in0 = 4'h0;
    end else if (sck0 && !ps[0]) begin
      if (rc[0] < 64) trace[0][rc[0]] = {io_out0, io_oe0};
      rc[0] = rc[0] + 1;
      io_in0 = flash_nib(fl_word[0], rc[0]);
    end
    ps[0] = sck0;
    if (cs_n0) hi[0]++;
    else begin
      if (hi[0] != 0) chk("csh_gap0", 64'(hi[0] >= CSH), 64'd1);
      hi[0] = 0;
    end
  end

  always @(negedge clk) begin
    if (cs_n1) begin
      rc[1] = 0;
      io_in1 = 4'h0;
    end else if (sck1 && !ps[1]) begin
      if (rc[1] < 64) trace[1][rc[1]] = {io_out1, io_oe1};
      rc[1] = rc[1] + 1;
      io_in1 = flash_nib(fl_word[1], rc[1]);
    end
    ps[1] = sck1;
    if (cs_n1) hi[1]++;
    else begin
      if (hi[1] != 0) chk("csh_gap1", 64'(hi[1] >= CSH), 64'd1);
      hi[1] = 0;
    end
  end

  // expected {io_out, io_oe} at SCK rise i of a transaction
  function automatic logic [7:0] exp_pad(input logic [23:0] a, input int i);
    logic [31:0] hdr;
    logic [7:0]  op;
    hdr = {8'h6B, a};
    op  = 8'hEB;
    if (!QUAD) begin
      if (i < 32) return {3'b000, hdr[31-i], 4'b0001};
      return 8'h00;
    end
    if (i < 8)  return {3'b000, op[7-i], 4'b0001};
    if (i < 14) return {a[23 - 4*(i-8) -: 4], 4'b1111};
    if (i < 16) return 8'h0F;
    return 8'h00;
  endfunction

  // ---------------- per-DUT accessors ----------------
  function automatic logic done_of(input int d);  return d == 0 ? bus0.done : bus1.done; endfunction
  function automatic logic busy_of(input int d);  return d == 0 ? bus0.busy : bus1.busy; endfunction
  function automatic logic csn_of(input int d);   return d == 0 ? cs_n0 : cs_n1; endfunction
  function automatic logic [31:0] res_of(input int d);
    return d == 0 ? bus0.fetch_result : bus1.fetch_result;
  endfunction

  task automatic set_fetch(input int d, input logic f, input logic [23:0] a);
    if (d == 0) begin bus0.fetch = f; bus0.fetch_addr = a; end
    else        begin bus1.fetch = f; bus1.fetch_addr = a; end
  endtask

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    while (busy_of(d) && n < 400) begin @(posedge clk); #1; n++; end
    chk("idle_wait", 64'(busy_of(d)), 64'd0);
  endtask

  // One complete fetch; poke=1 also fires an extra fetch while busy after done.
  task automatic run_fetch(input int d, input logic [23:0] a, input logic [31:0] w, input bit poke);
    int lat, n;
    lat = 1 + 2 * (d == 0 ? DIV0 : DIV1) * NSCK;
    fl_word[d] = w;
    @(posedge clk); #1;
    set_fetch(d, 1'b1, a);
    @(posedge clk); #1;
    set_fetch(d, 1'b0, 24'($urandom()));
    chk("busy_on_accept", 64'(busy_of(d)), 64'd1);
    chk("cs_low_on_accept", 64'(csn_of(d)), 64'd0);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done_of(d) && n < lat + 20);
    chk("done_seen", 64'(done_of(d)), 64'd1);
    chk("latency", 64'(n), 64'(lat));
    chk("result", 64'(res_of(d)), 64'(w));
    chk("sck_rises", 64'(rc[d]), 64'(NSCK));
    for (int i = 0; i < NSCK; i++)
      chk($sformatf("pad_rise%0d", i), 64'(trace[d][i]), 64'(exp_pad(a, i)));
    @(posedge clk); #1;
    chk("done_one_cycle", 64'(done_of(d)), 64'd0);
    chk("busy_in_csh", 64'(busy_of(d)), 64'd1);
    if (poke) set_fetch(d, 1'b1, a ^ 24'h5A5A5A);
    @(posedge clk); #1;
    set_fetch(d, 1'b0, a);
    chk("busy_low_after_csh", 64'(busy_of(d)), 64'd0);
    chk("result_hold", 64'(res_of(d)), 64'(w));
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    logic [23:0] a;
    int dones, doubles, exp_dones, lat0, period, n;
    logic pd;

    rst_n = 1'b1;
    set_fetch(0, 1'b0, 24'h0);
    set_fetch(1, 1'b0, 24'h0);
    io_in0 = 4'h0; io_in1 = 4'h0;
    for (int k = 0; k < 2; k++) begin rc[k] = 0; ps[k] = 1'b0; hi[k] = 0; fl_word[k] = 32'h0; end
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", 64'(bus0.fetch_result), 64'd0);
    chk("rst_done", 64'(bus0.done), 64'd0);
    chk("rst_busy", 64'(bus0.busy), 64'd0);
    chk("rst_cs_n", 64'(cs_n0), 64'd1);
    chk("rst_sck", 64'(sck0), 64'd0);
    chk("rst_io", 64'({io_out0, io_oe0}), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // directed read
    a = QUAD ? 24'h020ABC : 24'h002000;
    run_fetch(0, a, 32'h1234ABCD, 1'b1);
    // the poked fetch during CSH must have been dropped
    repeat (3) @(posedge clk);
    #1;
    chk("ignored_cs_n", 64'(cs_n0), 64'd1);
    chk("ignored_busy", 64'(bus0.busy), 64'd0);
    chk("ignored_result", 64'(bus0.fetch_result), 64'h1234ABCD);
    run_fetch(0, 24'h010004, 32'hFFFFFFFF, 1'b0);

    // reset in the middle of a read
    fl_word[0] = 32'hDEADBEEF;
    @(posedge clk); #1;
    set_fetch(0, 1'b1, 24'h123456);
    @(posedge clk); #1;
    set_fetch(0, 1'b0, 24'h0);
    repeat (50) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cs_n", 64'(cs_n0), 64'd1);
    chk("arst_sck", 64'(sck0), 64'd0);
    chk("arst_oe", 64'(io_oe0), 64'd0);
    chk("arst_busy", 64'(bus0.busy), 64'd0);
    chk("arst_result", 64'(bus0.fetch_result), 64'd0);
    pd = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (c == 2) rst_n = 1'b1;
      pd = pd | bus0.done;
    end
    chk("arst_no_done", 64'(pd), 64'd0);
    chk("arst_cs_stays_high", 64'(cs_n0), 64'd1);
    run_fetch(0, 24'h0ABCDE, 32'h0F1E2D3C, 1'b0);

    // slower SCK
    run_fetch(1, 24'h002000, 32'($urandom()), 1'b0);

    // randomized reads on both instances
    for (int k = 0; k < 6; k++) begin
      a = 24'($urandom());
      w = 32'($urandom());
      run_fetch((k % 3 == 2) ? 1 : 0, a, w, 1'($urandom_range(0, 1)));
    end
    wait_idle(0);
    wait_idle(1);

    // fetch held high: one read per IDLE window, single-cycle done each
    w = 32'($urandom());
    a = 24'($urandom());
    fl_word[0] = w;
    lat0   = 1 + 2 * DIV0 * NSCK;
    period = lat0 + CSH + 1;
    exp_dones = 0;
    for (int s = 1; s + lat0 <= 300; s += period) exp_dones++;
    dones = 0; doubles = 0; pd = 1'b0;
    @(posedge clk); #1;
    set_fetch(0, 1'b1, a);
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk); #1;
      if (bus0.done) begin
        dones++;
        if (pd) doubles++;
        chk("held_result", 64'(bus0.fetch_result), 64'(w));
      end
      pd = bus0.done;
    end
    set_fetch(0, 1'b0, 24'h0);
    chk("held_done_count", 64'(dones), 64'(exp_dones));
    chk("held_done_doubles", 64'(doubles), 64'd0);
    n = 0;
    while (bus0.busy && n < 400) begin @(posedge clk); #1; n++; end
    chk("held_final_idle", 64'(bus0.busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
